// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (combinational read, clocked write) between N_REQ requesters.
// Latency: request seen at edge E0 -> one ACCESS cycle -> ack/rdata valid in the following cycle (one transaction per 2 cycles).
// Backpressure: requesters hold req until their ack; a requester whose ack is high is masked from arbitration in that cycle.
module ram_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [N_REQ*WIDTH-1:0]      wdata,
  output logic [N_REQ-1:0]            ack,
  output logic [WIDTH-1:0]            rdata,
  output logic                        busy,
  output logic                        mem_load,
  output logic [ADDR_WIDTH-1:0]       mem_address,
  output logic [WIDTH-1:0]            mem_in,
  input  logic [WIDTH-1:0]            mem_out
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      r_gnt_idx;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [N_REQ-1:0]      r_ack;
  logic [WIDTH-1:0]      r_rdata;

  logic [N_REQ-1:0]      w_cand;
  logic                  w_found;
  logic [IDX_W-1:0]      w_win;
  int                    w_idx;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [WIDTH-1:0]      w_sel_wdata;
  logic [IDX_W-1:0]      w_next_ptr;

  // Candidates exclude the requester being acked this cycle so a late req drop cannot re-issue.
  assign w_cand = req & ~r_ack;

  // Scan candidates starting at the round-robin pointer; the first set bit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_REQ) begin
        w_idx = w_idx - N_REQ;
      end
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(w_idx);
      end
    end
  end

  // Only the winner's fields are muxed out, so unselected requesters cannot leak X into state.
  always_comb begin
    w_sel_we    = we[w_win];
    w_sel_addr  = addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
    w_sel_wdata = wdata[int'(w_win)*WIDTH +: WIDTH];
  end

  // Pointer moves to the requester after the one just served, wrapping at N_REQ-1.
  always_comb begin
    if (r_gnt_idx == IDX_W'(N_REQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = r_gnt_idx + 1'b1;
    end
  end

  // Two-state controller: arbitrate and latch in IDLE, perform the memory access in ACCESS.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ack     <= '0;
      r_rdata   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt_idx <= w_win;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          // mem_out is sampled on the same edge as any write, so writes return the old content.
          r_rdata          <= mem_out;
          r_ack[r_gnt_idx] <= 1'b1;
          r_rr_ptr         <= w_next_ptr;
          r_state          <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Load is gated by state so an asynchronous reset mid-access drops it immediately.
  assign mem_load    = (r_state == ACCESS) && r_we;
  assign mem_address = r_addr;
  assign mem_in      = r_wdata;
  assign busy        = (r_state == ACCESS);
  assign ack         = r_ack;
  assign rdata       = r_rdata;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin controller that shares one single-port RAM8-style memory between N_REQ requesters.
- The memory has a combinational read port, a clocked write port, and `load`/`address`/`in`/`out` pins.
- Sits between the requesting blocks and the memory instance. It serialises accesses and returns read data through a per-requester ack handshake.
- Sustains one transaction every 2 cycles.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, data word width
- ADDR_WIDTH, 3, memory address width (8 words)

Ports:
- clock  input  1  system clock, all state updates on posedge
- reset_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester request; held high until ack
- we  input  N_REQ  per-requester write enable (1 = write, 0 = read)
- addr  input  N_REQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  input  N_REQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH]
- ack  output  N_REQ  one-cycle completion pulse, one-hot or zero
- rdata  output  WIDTH  data returned with ack
- busy  output  1  high while in ACCESS
- mem_load  output  1  to memory load pin
- mem_address  output  ADDR_WIDTH  to memory address pin
- mem_in  output  WIDTH  to memory data-in pin
- mem_out  input  WIDTH  from memory data-out pin (combinational read)

Behaviour:
- Interface: one clock, `clock`. Reset is asynchronous and active-low, `reset_n`.
- Reset state, entered immediately on reset_n low:
  - state = IDLE, rr_ptr = 0
  - ack = 0, rdata = 0, busy = 0
  - mem_load = 0, mem_address = 0, mem_in = 0
  - grant index and latched we/addr/wdata = 0
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - Arbitration candidates: req & ~ack. A requester whose ack is high this cycle is masked, so a requester that drops req one cycle late does not issue a duplicate.
  - If any candidate exists: pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Latch the winner's index, we, addr and wdata into registers, then go to ACCESS.
  - If no candidate: stay in IDLE.
  - mem_load = 0 throughout IDLE.
- ACCESS (exactly one cycle):
  - Outputs driven from latched registers: mem_address = latched addr, mem_in = latched wdata, mem_load = latched we (combinational from state, so it is 0 outside ACCESS).
  - busy = 1.
  - At the closing edge: the memory performs any write; rdata <= mem_out; ack[winner] <= 1; rr_ptr <= (winner+1) mod N_REQ; state <= IDLE.
- Read/write data:
  - Reads: rdata = memory content at addr.
  - Writes: rdata = content before the write (mem_out is sampled in the same cycle as the write edge).
  - rdata holds its value until the next transaction completes.
- ack is high for exactly one cycle, the IDLE cycle after ACCESS. It is cleared on the next edge unconditionally.
- Latency: req rises before edge E0 -> ACCESS in cycle E0..E1 -> ack and rdata valid in cycle E1..E2.
- Back-to-back operation: arbitration in the ack cycle may grant a different requester. Minimum spacing between acks is 2 cycles.
- req dropped while in ACCESS: the transaction still completes and acks (inputs were latched in IDLE).
- Changing addr/we/wdata after the grant has no effect.
- Reset mid-ACCESS: mem_load falls to 0 asynchronously. No write is guaranteed, no ack is issued, rr_ptr returns to 0.
- Simultaneous requests: exactly one grant per arbitration. Fairness: a continuously requesting requester waits at most N_REQ-1 other grants.
- rr_ptr wraps from N_REQ-1 to 0.
- All inputs are synchronous to clock. No X-propagation from unselected requesters' addr/wdata into any output.

Test Plan:
- Reset / idle: reset_n low mid-run, all req = 0 -> every output 0; busy = 0 and ack = 0 for 10 cycles after release.
- Single write then read:
  - req[1] with we=1, addr=5, wdata=16'h1234 -> ack[1] one cycle at E1; mem_load high only in the ACCESS cycle.
  - Then req[1] with we=0, addr=5 -> ack[1] with rdata = 16'h1234.
- All four requesting continuously, each reading its own preloaded address (mem[i] = 16'hA000+i) -> ack order 0,1,2,3,0 with spacing 2 cycles and matching rdata; no requester acked twice within a sweep.
- Round-robin pointer:
  - Grant requester 2 alone, then raise req[0] and req[3] together -> req[3] is acked first, then req[0].
  - Grant requester 3 -> rr_ptr wraps to 0.
- Late req drop: requester keeps req high during its ack cycle and drops it the next cycle -> no second ack is generated.
- Reset during ACCESS (write of 16'hFFFF to addr 2, previous content 16'h0042):
  - Assert reset_n low mid-cycle -> mem_load drops immediately, no ack issued.
  - Readback of addr 2 is 16'h0042 provided reset arrived before the edge.
